mux_rr_reg: RTL and testbench

- N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input channel and on the single output.
- Generalises the 2-way combinational select to N channels.
- Two modes:
  - fixed-select: channel chosen by `sel`.
  - round-robin arbitration: fair selection among all requesting channels.
- Sits between multiple producers (e.g. PC/ALU/memory result sources) and one consumer stage of the multicycle datapath. The output register decouples timing.

---
 rtl/mux_rr_reg.sv | 106 ++++++++++
 tb/tb_mux_rr_reg.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_reg.sv
// N-channel registered multiplexer with valid/ready handshakes.
// Channels are chosen by a fixed index or by a round-robin pointer.
module mux_rr_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_sel
);

  // One extra bit so channel-index arithmetic can exceed N-1 before wrapping.
  localparam int unsigned CW = SELW + 1;

  logic [WIDTH-1:0] ch_data [N];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             rr_ok;
  logic [SELW-1:0]  rr_gnt;
  logic [CW-1:0]    rr_idx;
  logic             fx_ok;
  logic             gnt_ok;
  logic [SELW-1:0]  gnt;
  logic             space;
  logic             load;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Round-robin scan starting at ptr, wrapping explicitly at N.
  always_comb begin
    rr_ok  = 1'b0;
    rr_gnt = '0;
    rr_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      rr_idx = {1'b0, ptr_q} + CW'(k);
      if (rr_idx >= CW'(N)) begin
        rr_idx = rr_idx - CW'(N);
      end
      if (!rr_ok && in_valid[rr_idx[SELW-1:0]]) begin
        rr_ok  = 1'b1;
        rr_gnt = rr_idx[SELW-1:0];
      end
    end
  end

  // Out-of-range sel values never grant.
  assign fx_ok  = ({1'b0, sel} < CW'(N)) && in_valid[sel];
  assign gnt_ok = mode ? rr_ok  : fx_ok;
  assign gnt    = mode ? rr_gnt : sel;

  assign space    = !out_valid_q || out_ready;
  assign load     = gnt_ok && space;
  assign in_ready = (rst_n && load) ? (N'(1) << gnt) : '0;

  // Output register and pointer next-state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[gnt];
      out_sel_d   = gnt;
      if (mode) begin
        ptr_d = (gnt == SELW'(N - 1)) ? '0 : gnt + SELW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: a 4-channel and a 5-channel instance checked
// against a cycle-level behavioural model under directed and random traffic.
module tb_mux_rr_reg;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel4;
  logic [2:0]  sel5;
  logic [31:0] ch [5];
  logic [3:0]  v4;
  logic [4:0]  v5;
  logic        ordy4, ordy5;

  logic [127:0] in_data4;
  logic [159:0] in_data5;
  logic [3:0]   in_ready4;
  logic [4:0]   in_ready5;
  logic [31:0]  out_data4, out_data5;
  logic         out_valid4, out_valid5;
  logic [1:0]   out_sel4;
  logic [2:0]   out_sel5;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state of each instance's output register and pointer.
  logic        m_valid [2];
  logic [31:0] m_data  [2];
  int          m_sel   [2];
  int          m_ptr   [2];

  int rr_exp [6] = '{0, 1, 3, 0, 1, 3};

  assign in_data4 = {ch[3], ch[2], ch[1], ch[0]};
  assign in_data5 = {ch[4], ch[3], ch[2], ch[1], ch[0]};

  mux_rr_reg #(.WIDTH(32), .N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel4),
    .in_data(in_data4), .in_valid(v4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(ordy4),
    .out_sel(out_sel4)
  );

  mux_rr_reg #(.WIDTH(32), .N(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel5),
    .in_data(in_data5), .in_valid(v5), .in_ready(in_ready5),
    .out_data(out_data5), .out_valid(out_valid5), .out_ready(ordy5),
    .out_sel(out_sel5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Which channel the rules pick: fixed index, or first valid from ptr onward.
  function automatic void pick(input int n, input logic md, input int s,
                               input logic [4:0] v, input int p,
                               output logic ok, output int g);
    int c;
    ok = 1'b0;
    g  = 0;
    if (!md) begin
      g  = s;
      ok = (s < n) && v[s];
    end else begin
      for (int k = 0; k < n; k++) begin
        c = (p + k) % n;
        if (!ok && v[c]) begin
          ok = 1'b1;
          g  = c;
        end
      end
    end
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_data[d]  = '0;
      m_sel[d]   = 0;
      m_ptr[d]   = 0;
    end
  endtask

  // Check both instances mid-cycle, then advance the model across one edge.
  task automatic step();
    logic        ok, load, ordy;
    int          g, n, s;
    logic [4:0]  v, rdy;
    logic [31:0] od;
    logic        ov;
    int          os;
    logic        nv [2];
    logic [31:0] nd [2];
    int          ns [2];
    int          np [2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n    = (d == 0) ? 4 : 5;
      s    = (d == 0) ? int'(sel4) : int'(sel5);
      v    = (d == 0) ? {1'b0, v4} : v5;
      ordy = (d == 0) ? ordy4 : ordy5;
      rdy  = (d == 0) ? {1'b0, in_ready4} : in_ready5;
      ov   = (d == 0) ? out_valid4 : out_valid5;
      od   = (d == 0) ? out_data4 : out_data5;
      os   = (d == 0) ? int'(out_sel4) : int'(out_sel5);
      pick(n, mode, s, v, m_ptr[d], ok, g);
      load = ok && (!m_valid[d] || ordy);
      check($sformatf("in_ready_n%0d", n), 64'(rdy), load ? (64'(1) << g) : 64'(0));
      check($sformatf("out_valid_n%0d", n), 64'(ov), 64'(m_valid[d]));
      check($sformatf("out_data_n%0d", n), 64'(od), 64'(m_data[d]));
      check($sformatf("out_sel_n%0d", n), 64'(os), 64'(m_sel[d]));
      nv[d] = m_valid[d];
      nd[d] = m_data[d];
      ns[d] = m_sel[d];
      np[d] = m_ptr[d];
      if (load) begin
        nv[d] = 1'b1;
        nd[d] = ch[g];
        ns[d] = g;
        if (mode) np[d] = (g + 1) % n;
      end else if (m_valid[d] && ordy) begin
        nv[d] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = nv[d];
      m_data[d]  = nd[d];
      m_sel[d]   = ns[d];
      m_ptr[d]   = np[d];
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mode  = 1'b1;
    sel4  = '0;
    sel5  = '0;
    v4    = 4'b1111;
    v5    = 5'b11111;
    ordy4 = 1'b1;
    ordy5 = 1'b1;
    for (int i = 0; i < 5; i++) ch[i] = 32'h1000_0000 + 32'(i);
    model_reset();

    // Reset holds everything idle even with all channels valid.
    #12;
    check("rst_in_ready", 64'(in_ready4), 64'(0));
    check("rst_in_ready5", 64'(in_ready5), 64'(0));
    check("rst_out_valid", 64'(out_valid4), 64'(0));
    check("rst_out_data", 64'(out_data4), 64'(0));
    check("rst_out_sel", 64'(out_sel4), 64'(0));

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin fairness over channels 0,1,3.
    v4 = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_seq", 64'(out_sel4), 64'(rr_exp[i]));
    end

    // Fixed select; the 5-channel instance gets an out-of-range index.
    mode     = 1'b0;
    sel4     = 2'd2;
    sel5     = 3'd5;
    ch[2]    = 32'hdeadbeef;
    v4       = 4'b1111;
    v5       = 5'b11111;
    step();
    check("fixed_data", 64'(out_data4), 64'h0000_0000_dead_beef);
    check("fixed_sel", 64'(out_sel4), 64'(2));
    check("sel_oor_drain", 64'(out_valid5), 64'(0));
    step();

    // Backpressure: output frozen while the consumer stalls.
    sel4  = 2'd1;
    ch[1] = 32'hbeefdead;
    step();
    ordy4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ch[1] = $urandom;
      step();
      check("stall_data", 64'(out_data4), 64'h0000_0000_beef_dead);
      check("stall_sel", 64'(out_sel4), 64'(1));
    end
    ordy4 = 1'b1;
    ch[1] = 32'h0bad_cafe;
    step();
    check("drain_load_valid", 64'(out_valid4), 64'(1));
    check("drain_load_data", 64'(out_data4), 64'h0000_0000_0bad_cafe);

    // Mode switch: pointer retained across a fixed-select interval.
    mode = 1'b1;
    v4   = 4'b0010;
    step();
    mode = 1'b0;
    sel4 = 2'd0;
    v4   = 4'b1111;
    step();
    step();
    mode = 1'b1;
    step();
    check("mode_resume", 64'(out_sel4), 64'(2));

    // Asynchronous reset during a stall.
    ordy4 = 1'b0;
    step();
    check("pre_rst_valid", 64'(out_valid4), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(out_valid4), 64'(0));
    check("async_ready", 64'(in_ready4), 64'(0));
    check("async_data", 64'(out_data4), 64'(0));
    model_reset();
    #1;
    rst_n = 1'b1;
    ordy4 = 1'b1;
    step();
    check("post_rst_ptr", 64'(out_sel4), 64'(0));

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      mode  = ($urandom_range(0, 3) != 0);
      sel4  = 2'($urandom_range(0, 3));
      sel5  = 3'($urandom_range(0, 7));
      v4    = 4'($urandom);
      v5    = 5'($urandom);
      ordy4 = ($urandom_range(0, 3) != 0);
      ordy5 = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 5; i++) ch[i] = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
